// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver
//
// Priority resolver for an 8259-style interrupt controller. It sits right after
// the interrupt request register and does the following:
//   - Latches requests into a pending register.
//   - Resolves the highest eligible request against the in-service register
//     (fully nested).
//   - Raises int_req.
//   - Runs the two-pulse INTA acknowledge.
//   - Handles the EOI commands.
//   - Produces the interrupt vector.
//
// Build option:
//   PIC_PRIORITY_ROTATION_EN  - When defined, the rotate input is honoured and a
//                               lowest-priority register is kept. When undefined,
//                               priority is fixed (IR0 highest, IR7 lowest) and
//                               rotate is ignored.
module pic_priority_resolver #(
    parameter int NUM_IR         = 8,
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] irr,
    input  logic [NUM_IR-1:0] imr,
    input  logic              ltim,
    input  logic              inta,
    input  logic              eoi_ns,
    input  logic              eoi_s,
    input  logic [2:0]        eoi_level,
    input  logic              rotate,
    input  logic              aeoi,
    input  logic [4:0]        vector_base,
    output logic              int_req,
    output logic [7:0]        vector_out,
    output logic              vector_valid,
    output logic [NUM_IR-1:0] isr
);

    typedef enum logic {
        IDLE = 1'b0,
        ACK1 = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              ack1_fire;
    logic              ack2_fire;

    logic              inta_d;
    logic              inta_edge;

    logic [NUM_IR-1:0] pending;
    logic [NUM_IR-1:0] pending_next;
    logic [NUM_IR-1:0] ack_clr;
    logic [NUM_IR-1:0] isr_set;
    logic [NUM_IR-1:0] isr_clr;
    logic [NUM_IR-1:0] isr_next;

    logic [2:0]        level;
    logic [2:0]        level_next;
    logic              spurious;
    logic              spurious_next;

    logic [7:0]        vector_next;
    logic              vector_valid_next;

    logic [2:0]        lowest_pri;
    logic [2:0]        lowest_pri_next;
    logic [2:0]        highest_pri;

    logic [3:0]        req_top;
    logic [3:0]        isr_top;
    logic              eligible;

    // Highest-priority set bit of v, where hi is the top-priority level and
    // priority descends cyclically from there. The result is {found, level}.
    function automatic logic [3:0] find_top(input logic [NUM_IR-1:0] v,
                                            input logic [2:0]        hi);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = NUM_IR - 1; k >= 0; k--) begin
            lvl = hi + 3'(k);
            if (v[lvl]) begin
                res = {1'b1, lvl};
            end
        end
        return res;
    endfunction

    // Cyclic distance from the top-priority level; smaller means higher priority.
    function automatic logic [2:0] rank_of(input logic [2:0] lvl,
                                           input logic [2:0] hi);
        return lvl - hi;
    endfunction

    assign highest_pri = lowest_pri + 3'd1;
    assign req_top     = find_top(pending & ~imr, highest_pri);
    assign isr_top     = find_top(isr, highest_pri);

    // The best pending request only has to beat the best in-service level. If
    // it cannot, then no lower pending request can either.
    assign eligible = req_top[3] &&
                      (!isr_top[3] ||
                       (rank_of(req_top[2:0], highest_pri) < rank_of(isr_top[2:0], highest_pri)));

    assign inta_edge = inta & ~inta_d;

    // Acknowledge sequencer: state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Acknowledge sequencer: next state and per-pulse fire strobes.
    always_comb begin
        state_next = state;
        ack1_fire  = 1'b0;
        ack2_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (inta_edge) begin
                    state_next = ACK1;
                    ack1_fire  = 1'b1;
                end
            end
            ACK1: begin
                if (inta_edge) begin
                    state_next = IDLE;
                    ack2_fire  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next-state for ISR, pending, latched level, vector and rotation.
    // EOI is applied after the acknowledge, so an EOI rotation overrides an
    // AEOI rotation in the same cycle. Set beats clear on the same ISR bit.
    always_comb begin
        ack_clr           = '0;
        isr_set           = '0;
        isr_clr           = '0;
        level_next        = level;
        spurious_next     = spurious;
        vector_next       = vector_out;
        vector_valid_next = 1'b0;
        lowest_pri_next   = lowest_pri;

        if (ack1_fire) begin
            if (eligible) begin
                isr_set[req_top[2:0]] = 1'b1;
                ack_clr[req_top[2:0]] = 1'b1;
                level_next            = req_top[2:0];
                spurious_next         = 1'b0;
            end else begin
                level_next    = 3'(SPURIOUS_LEVEL);
                spurious_next = 1'b1;
            end
        end

        if (ack2_fire) begin
            vector_next       = {vector_base, level};
            vector_valid_next = 1'b1;
            if (aeoi && !spurious) begin
                isr_clr[level] = 1'b1;
                if (rotate) begin
                    lowest_pri_next = level;
                end
            end
        end

        if (eoi_s) begin
            isr_clr[eoi_level] = 1'b1;
            if (rotate) begin
                lowest_pri_next = eoi_level;
            end
        end else if (eoi_ns && isr_top[3]) begin
            isr_clr[isr_top[2:0]] = 1'b1;
            if (rotate) begin
                lowest_pri_next = isr_top[2:0];
            end
        end

        isr_next     = (isr & ~isr_clr) | isr_set;
        pending_next = (pending & ~ack_clr) | irr;
        if (ltim) begin
            pending_next = pending_next & irr;
        end
    end

    // Request, in-service and acknowledge bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inta_d       <= 1'b0;
            pending      <= '0;
            isr          <= '0;
            level        <= 3'd0;
            spurious     <= 1'b0;
            int_req      <= 1'b0;
            vector_out   <= 8'd0;
            vector_valid <= 1'b0;
        end else begin
            inta_d       <= inta;
            pending      <= pending_next;
            isr          <= isr_next;
            level        <= level_next;
            spurious     <= spurious_next;
            int_req      <= eligible;
            vector_out   <= vector_next;
            vector_valid <= vector_valid_next;
        end
    end

`ifdef PIC_PRIORITY_ROTATION_EN
    // Rotating priority: remembers the current lowest-priority level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lowest_pri <= 3'd7;
        end else begin
            lowest_pri <= lowest_pri_next;
        end
    end
`else
    // Fixed priority: IR7 is always lowest, and rotation requests are dropped.
    logic [2:0] unused_rotation;
    assign lowest_pri      = 3'd7;
    assign unused_rotation = lowest_pri_next ^ {2'b00, rotate};
`endif

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Testbench for pic_priority_resolver.
// It runs directed scenarios, followed by randomized traffic. The DUT is
// checked every cycle against a behavioural model that works with priority
// ranks.
module tb_pic_priority_resolver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irr;
    logic [7:0] imr;
    logic       ltim;
    logic       inta;
    logic       eoi_ns;
    logic       eoi_s;
    logic [2:0] eoi_level;
    logic       rotate;
    logic       aeoi;
    logic [4:0] vector_base;
    logic       int_req;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic [7:0] isr;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [7:0] m_pending;
    logic [7:0] m_isr;
    int         m_lp;
    logic       m_in_ack;
    int         m_L;
    logic       m_spur;
    logic       m_int_req;
    logic [7:0] m_vec;
    logic       m_vv;
    logic       m_inta_d;

    pic_priority_resolver dut (
        .clk          (clk),
        .rst          (rst),
        .irr          (irr),
        .imr          (imr),
        .ltim         (ltim),
        .inta         (inta),
        .eoi_ns       (eoi_ns),
        .eoi_s        (eoi_s),
        .eoi_level    (eoi_level),
        .rotate       (rotate),
        .aeoi         (aeoi),
        .vector_base  (vector_base),
        .int_req      (int_req),
        .vector_out   (vector_out),
        .vector_valid (vector_valid),
        .isr          (isr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Priority rank: 0 is the highest level, which is the one after lowest_pri.
    function automatic int rank(input int lvl);
        return (lvl - m_lp - 1 + 16) % 8;
    endfunction

    function automatic int top_of(input logic [7:0] v);
        int best;
        best = -1;
        for (int i = 0; i < 8; i++) begin
            if (v[i] && (best < 0 || rank(i) < rank(best))) begin
                best = i;
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_pending = 8'h00;
        m_isr     = 8'h00;
        m_lp      = 7;
        m_in_ack  = 1'b0;
        m_L       = 0;
        m_spur    = 1'b0;
        m_int_req = 1'b0;
        m_vec     = 8'h00;
        m_vv      = 1'b0;
        m_inta_d  = 1'b0;
    endtask

    task automatic model_update();
        int         cand;
        int         itop;
        int         win;
        int         lp_n;
        logic       edge_now;
        logic [7:0] set_m;
        logic [7:0] clr_m;
        logic [7:0] ackc;
        logic [7:0] np;
        cand     = top_of(m_pending & ~imr);
        itop     = top_of(m_isr);
        win      = (cand >= 0 && (itop < 0 || rank(cand) < rank(itop))) ? cand : -1;
        edge_now = inta && !m_inta_d;
        set_m    = 8'h00;
        clr_m    = 8'h00;
        ackc     = 8'h00;
        lp_n     = m_lp;
        m_vv     = 1'b0;
        if (!m_in_ack && edge_now) begin
            m_in_ack = 1'b1;
            if (win >= 0) begin
                set_m[win] = 1'b1;
                ackc[win]  = 1'b1;
                m_L        = win;
                m_spur     = 1'b0;
            end else begin
                m_L    = 7;
                m_spur = 1'b1;
            end
        end else if (m_in_ack && edge_now) begin
            m_in_ack = 1'b0;
            m_vec    = {vector_base, 3'(m_L)};
            m_vv     = 1'b1;
            if (aeoi && !m_spur) begin
                clr_m[m_L] = 1'b1;
                if (rotate) lp_n = m_L;
            end
        end
        if (eoi_s) begin
            clr_m[eoi_level] = 1'b1;
            if (rotate) lp_n = int'(eoi_level);
        end else if (eoi_ns && itop >= 0) begin
            clr_m[itop] = 1'b1;
            if (rotate) lp_n = itop;
        end
        np = (m_pending & ~ackc) | irr;
        if (ltim) np = np & irr;
        m_pending = np;
        m_isr     = (m_isr & ~clr_m) | set_m;
`ifdef PIC_PRIORITY_ROTATION_EN
        m_lp      = lp_n;
`endif
        m_int_req = (win >= 0);
        m_inta_d  = inta;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("int_req", 32'(int_req), 32'(m_int_req));
        check("isr", 32'(isr), 32'(m_isr));
        check("vector_valid", 32'(vector_valid), 32'(m_vv));
        check("vector_out", 32'(vector_out), 32'(m_vec));
    endtask

    task automatic clear_inputs();
        irr       = 8'h00;
        imr       = 8'h00;
        ltim      = 1'b0;
        inta      = 1'b0;
        eoi_ns    = 1'b0;
        eoi_s     = 1'b0;
        eoi_level = 3'd0;
        rotate    = 1'b0;
        aeoi      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_irr(input logic [7:0] v);
        irr = v;
        step();
        irr = 8'h00;
        step();
    endtask

    task automatic ack_pair(output logic [7:0] vec, output logic vv);
        inta = 1'b1; step();
        inta = 1'b0; step();
        inta = 1'b1; step();
        vec = vector_out;
        vv  = vector_valid;
        inta = 1'b0; step();
    endtask

    initial begin
        logic [7:0] vec;
        logic       vv;
        vector_base = 5'h08;
        clear_inputs();
        model_reset();
        rst = 1'b1;
        #12;
        check("rst_int_req", 32'(int_req), 32'h0);
        check("rst_isr", 32'(isr), 32'h0);
        check("rst_vv", 32'(vector_valid), 32'h0);
        check("rst_vec", 32'(vector_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic service of IR2 out of {2,5}
        irr = 8'h24; step();
        check("t1_int_req_lat", 32'(int_req), 32'h0);
        irr = 8'h00; step();
        check("t1_int_req", 32'(int_req), 32'h1);
        ack_pair(vec, vv);
        check("t1_vec", 32'(vec), 32'h42);
        check("t1_vv", 32'(vv), 32'h1);
        check("t1_vv_drop", 32'(vector_valid), 32'h0);
        check("t1_isr", 32'(isr), 32'h04);
        check("t1_nested_block", 32'(int_req), 32'h0);

        // Higher-priority IR0 nests over IR2
        pulse_irr(8'h01);
        check("t2_int_req", 32'(int_req), 32'h1);
        ack_pair(vec, vv);
        check("t2_vec", 32'(vec), 32'h40);
        check("t2_isr", 32'(isr), 32'h05);

        // EOI commands
        do_reset();
        pulse_irr(8'h08);
        ack_pair(vec, vv);
        pulse_irr(8'h02);
        ack_pair(vec, vv);
        check("t3_isr", 32'(isr), 32'h0A);
        eoi_ns = 1'b1; step(); eoi_ns = 1'b0;
        check("t3_eoi_ns", 32'(isr), 32'h08);
        eoi_s = 1'b1; eoi_level = 3'd3; step();
        check("t3_eoi_s3", 32'(isr), 32'h00);
        eoi_level = 3'd5; step(); eoi_s = 1'b0;
        check("t3_eoi_s5", 32'(isr), 32'h00);

        // Spurious acknowledge, both with no request and with a dropped level request
        do_reset();
        ack_pair(vec, vv);
        check("t4_spur_vec", 32'(vec), 32'h47);
        check("t4_spur_isr", 32'(isr), 32'h00);
        ltim = 1'b1;
        pulse_irr(8'h04);
        ack_pair(vec, vv);
        check("t4_ltim_vec", 32'(vec), 32'h47);
        check("t4_ltim_isr", 32'(isr), 32'h00);
        ltim = 1'b0;

        // Automatic EOI, with rotation when it is built in
        do_reset();
        aeoi = 1'b1; rotate = 1'b1;
        pulse_irr(8'h08);
        ack_pair(vec, vv);
        check("t5_vec3", 32'(vec), 32'h43);
        check("t5_isr", 32'(isr), 32'h00);
        pulse_irr(8'h81);
        ack_pair(vec, vv);
`ifdef PIC_PRIORITY_ROTATION_EN
        check("t5_rot_vec", 32'(vec), 32'h47);
`else
        check("t5_fixed_vec", 32'(vec), 32'h40);
`endif
        check("t5_isr2", 32'(isr), 32'h00);
        aeoi = 1'b0; rotate = 1'b0;

        // Reset between the two INTA pulses
        do_reset();
        pulse_irr(8'h04);
        inta = 1'b1; step();
        inta = 1'b0; step();
        check("t6_isr_pre", 32'(isr), 32'h04);
        rst = 1'b1;
        #1;
        check("t6_rst_isr", 32'(isr), 32'h0);
        check("t6_rst_int_req", 32'(int_req), 32'h0);
        check("t6_rst_vec", 32'(vector_out), 32'h0);
        check("t6_rst_vv", 32'(vector_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        inta = 1'b1; step();
        check("t6_no_vv", 32'(vector_valid), 32'h0);
        inta = 1'b0; step();
        check("t6_no_vv2", 32'(vector_valid), 32'h0);
        inta = 1'b1; step();
        inta = 1'b0; step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            irr       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            inta      = ($urandom_range(0, 2) == 0) ? ~inta : inta;
            eoi_ns    = ($urandom_range(0, 9) == 0);
            eoi_s     = ($urandom_range(0, 11) == 0);
            eoi_level = 3'($urandom);
            rotate    = 1'($urandom);
            if (c % 50 == 0)  imr  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            if (c % 200 == 0) aeoi = 1'($urandom);
            if (c % 300 == 0) ltim = 1'($urandom);
            if (c % 100 == 0) vector_base = 5'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pic_priority_resolver.md
Name: pic_priority_resolver

Overview:
- Stage directly downstream of the interrupt request register of the 8259-style PIC.
- Latches masked requests (pulse or level) into a pending register and resolves priority against the in-service register (ISR), fully nested.
- Raises int_req, runs the two-pulse INTA acknowledge sequence, sets/clears ISR, and emits the 8-bit vector.

Parameters:
- NUM_IR, 8, number of interrupt levels; fixed at 8, index width 3.
- SPURIOUS_LEVEL, 7, level reported when first INTA finds no eligible request.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- irr  in  8  request bits from IRR stage (already masked; one-cycle pulses in edge mode).
- imr  in  8  interrupt mask register; 1 = masked.
- ltim  in  1  1 = level mode: pending bit drops when irr bit low.
- inta  in  1  synchronous acknowledge level from control logic; rising edge = one INTA pulse.
- eoi_ns  in  1  one-cycle non-specific EOI strobe.
- eoi_s  in  1  one-cycle specific EOI strobe.
- eoi_level  in  3  level for specific EOI.
- rotate  in  1  qualifies EOI strobes as rotate-on-EOI.
- aeoi  in  1  automatic EOI on second INTA.
- vector_base  in  5  ICW2 T7..T3.
- int_req  out  1  registered interrupt request to CPU.
- vector_out  out  8  {vector_base, level}.
- vector_valid  out  1  one-cycle strobe, vector_out valid.
- isr  out  8  in-service register.

Behaviour:
- Reset (async, rst=1): pending=0, isr=0, int_req=0, vector_out=0, vector_valid=0, lowest_pri=7, FSM=IDLE.
- pending_next = (pending & ~ack_clr) | irr; in ltim=1 additionally & irr. A new irr bit coincident with its own ack clear is kept (set wins).
- Priority order: highest = (lowest_pri+1) mod 8, descending cyclically to lowest_pri.
- Eligible request: pending & ~imr, level strictly higher priority than highest-priority set ISR bit (ISR=0: any).
- int_req registered: asserted cycle after an eligible request exists; deasserts cycle after none exists.
- inta edge detect via registered inta_d; edge = inta & ~inta_d.
- FSM IDLE: inta edge -> ACK1. Select highest eligible level L (pre-edge state); set isr[L], clear pending[L]. None eligible -> L=SPURIOUS_LEVEL, spurious flag set, ISR/pending untouched.
- FSM ACK1: next inta edge -> IDLE; vector_out={vector_base,L}, vector_valid=1 for that cycle only. aeoi=1 and not spurious: clear isr[L]; rotate=1 also sets lowest_pri=L.
- vector_out holds last value until next ACK1 edge.
- Non-specific EOI: clear highest-priority set ISR bit; ISR=0 -> no effect. rotate=1: lowest_pri <= cleared level.
- Specific EOI: clear isr[eoi_level] (no-op if 0); rotate=1: lowest_pri <= eoi_level.
- eoi_ns and eoi_s together: specific wins.
- EOI and first-INTA edge in same cycle: both applied; selection uses pre-edge ISR; ISR bit set beats clear of the same bit.
- imr change mid-sequence: does not affect already-latched L.
- rst mid-sequence: immediate return to reset state; no vector_valid emitted.

Optional Feature:
- Macro PIC_PRIORITY_ROTATION_EN.
- Defined: rotate input honoured as above; lowest_pri register present.
- Undefined: fixed priority (IR0 highest, IR7 lowest); lowest_pri constant 7; rotate ignored; EOI only clears ISR.

Test Plan:
- Reset, irr=8'h24 pulse, imr=0 -> int_req=1 next cycle. Two INTA edges, vector_base=5'h08 -> isr=8'h04, vector_out=8'h42, vector_valid one cycle, pending=8'h20.
- isr=8'h04, irr pulse bit 5 -> int_req stays 0. irr pulse bit 0 -> int_req=1; ack -> isr=8'h05, vector level 0.
- aeoi=1, rotate=1 (macro defined), service IR3 -> isr=0 after second INTA; then irr=8'h81 -> IR7 wins over IR0 (lowest_pri=3, highest=4).
- First INTA edge with pending=0 -> vector_out={base,3'd7}, isr unchanged; ltim=1 request dropped before INTA gives same spurious result.
- isr=8'h0A, eoi_ns -> isr=8'h08; eoi_s level 3 -> isr=0; eoi_s level 5 on zero ISR -> no change.
- rst asserted between the two INTA edges -> all outputs 0, FSM IDLE; next single INTA edge produces no vector_valid.
